// File: rtl/msk_sbox_arb.sv
`default_nettype none
// ============================================================================
// msk_sbox_arb : round-robin issue arbiter and result tagging for one shared
//                masked 32-bit S-box layer (KS SubWord vs. ST SubBytes).
// Option       : MSK_SBOX_ARB_ZERO_IDLE_EN forces sbox_in to zero when idle.
// Revision     : 1.0
// ============================================================================
module msk_sbox_arb #(
  parameter int D   = 2,
  parameter int LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ks_valid,
  output logic            ks_ready,
  input  logic [32*D-1:0] ks_shares,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [32*D-1:0] st_shares,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  output logic [32*D-1:0] sbox_in,
  output logic            sbox_en,
  input  logic [32*D-1:0] sbox_out,
  output logic            ks_out_valid,
  output logic            st_out_valid,
  output logic [32*D-1:0] res_shares,
  output logic            busy
);

  localparam logic SRC_KS = 1'b0;
  localparam logic SRC_ST = 1'b1;

  logic           r_last_grant;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_src;

  logic w_grant;
  logic w_win_st;

  // Grant is gated by rst_n so ready/enable outputs drop the moment reset asserts.
  always_comb begin
    w_grant  = rst_n & rnd_valid & (ks_valid | st_valid);
    w_win_st = st_valid;
    if (ks_valid && st_valid) begin
      w_win_st = (r_last_grant == SRC_KS);
    end
  end

  always_comb begin
    ks_ready  = w_grant & ~w_win_st;
    st_ready  = w_grant &  w_win_st;
    sbox_en   = w_grant;
    rnd_ready = w_grant;
`ifdef MSK_SBOX_ARB_ZERO_IDLE_EN
    sbox_in = '0;
    if (w_grant) begin
      sbox_in = w_win_st ? st_shares : ks_shares;
    end
`else
    sbox_in = ks_ready ? ks_shares : st_shares;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SRC_ST;
    end else if (w_grant) begin
      r_last_grant <= w_win_st;
    end
  end

  generate
    if (LAT == 1) begin : g_tag_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_vld <= '0;
          r_tag_src <= '0;
        end else begin
          r_tag_vld <= w_grant;
          r_tag_src <= w_win_st;
        end
      end
    end else begin : g_tag_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_vld <= '0;
          r_tag_src <= '0;
        end else begin
          r_tag_vld <= {r_tag_vld[LAT-2:0], w_grant};
          r_tag_src <= {r_tag_src[LAT-2:0], w_win_st};
        end
      end
    end
  endgenerate

  assign ks_out_valid = r_tag_vld[LAT-1] & (r_tag_src[LAT-1] == SRC_KS);
  assign st_out_valid = r_tag_vld[LAT-1] & (r_tag_src[LAT-1] == SRC_ST);
  assign busy         = |r_tag_vld;
  assign res_shares   = sbox_out;

endmodule
`default_nettype wire

// File: doc/msk_sbox_arb.md
Name: msk_sbox_arb

Overview:
- Sequences one shared 32-bit masked S-box layer (4 byte S-boxes, d shares, HPC2 gadgets, fixed latency LAT) between two requesters: the key-schedule SubWord path (KS) and the round-state SubBytes path (ST).
- Arbitrates issue slots round-robin, gates issue on fresh-randomness availability and tags each in-flight word.
- Returns each result to its originator after exactly LAT cycles.
- Sits between the AES control FSM / key schedule and the masked S-box instance; the PRNG feeds its rnd handshake.

Parameters:
- d, 2, number of shares (d>=2)
- LAT, 4, S-box pipeline latency in cycles (LAT>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ks_valid  in  1  KS word request
- ks_ready  out  1  KS word accepted this cycle
- ks_shares  in  32*d  KS masked word, share-interleaved per bit (bit i share j at i*d+j)
- st_valid  in  1  ST word request
- st_ready  out  1  ST word accepted this cycle
- st_shares  in  32*d  ST masked word, same encoding
- rnd_valid  in  1  PRNG has a fresh randomness vector
- rnd_ready  out  1  randomness consumed this cycle (PRNG must advance)
- sbox_in  out  32*d  to S-box input register
- sbox_en  out  1  S-box stage-0 capture/enable
- sbox_out  in  32*d  S-box result, valid LAT cycles after matching sbox_en
- ks_out_valid  out  1  sbox_out belongs to KS this cycle
- st_out_valid  out  1  sbox_out belongs to ST this cycle
- res_shares  out  32*d  registered copy of sbox_out? no — combinational pass-through of sbox_out
- busy  out  1  any word in flight

Behaviour:
- Issue condition: at least one of ks_valid/st_valid, and rnd_valid=1. If rnd_valid=0: no grant, ready outputs 0, sbox_en=0, rnd_ready=0.
- Grant:
  - Only one requester valid: it wins.
  - Both valid: round-robin via 1-bit last_grant register. Winner is the one not granted last. last_grant resets to ST, so KS wins the first contention.
  - last_grant updates only on an actual grant.
- On grant (same cycle, combinational):
  - winner's ready=1, other ready=0
  - sbox_en=1, rnd_ready=1
  - sbox_in = winner's shares
- Ready outputs never depend on ready inputs (no combinational loops). Requesters hold valid and data stable until ready.
- Tag pipeline:
  - LAT-deep shift register of {valid, src}, src 0=KS, 1=ST. Stage 0 loads {grant, winner} each cycle; all stages shift every cycle.
  - Stage LAT-1 drives ks_out_valid=valid&~src and st_out_valid=valid&src.
  - Outputs are never both 1.
- No backpressure on results: receivers must accept in the out_valid cycle. Throughput 1 word/cycle. Back-to-back grants are legal.
- busy = OR of all tag valid bits.
- When sbox_en=0, sbox_in holds the mux output for the non-granted default (ST shares). The optional feature changes this.
- Reset (async assert, sync-released by design convention):
  - all tag valids 0, last_grant=ST
  - ks_ready, st_ready, sbox_en, rnd_ready, ks_out_valid, st_out_valid, busy all 0
  - Reset mid-operation discards in-flight words; no out_valid pulses for them after release.
- rnd_valid dropping mid-stream only blocks new issue. In-flight words still complete at LAT.
- res_shares = sbox_out unmodified. Share 0 carries any affine constant; the arbiter never alters shares.

Optional Feature:
- MSK_SBOX_ARB_ZERO_IDLE_EN defined: sbox_in is forced to all-zero whenever sbox_en=0. This avoids share recombination leakage from stale data toggling the S-box input.
- Undefined: sbox_in = ST shares when idle (cheaper mux, no gating).

Test Plan:
- Reset then KS only: ks_valid=1, ks_shares=word W, rnd_valid=1 → ks_ready=1 in cycle 0; ks_out_valid=1 exactly at cycle LAT (4); st_out_valid stays 0; busy high in cycles 1..4.
- Both valid continuously, rnd_valid=1 for 6 cycles → grants KS,ST,KS,ST,KS,ST; outputs alternate starting cycle LAT; rnd_ready=1 all 6 cycles.
- Both valid, rnd_valid=0 for 3 cycles then 1 → no ready/sbox_en/rnd_ready during the 3 cycles; first grant KS on cycle 3.
- Stream 3 ST words, assert rst_n=0 at cycle 2 for 1 cycle → all outputs 0 immediately; no st_out_valid afterwards; next grant after release is KS on contention.
- With MSK_SBOX_ARB_ZERO_IDLE_EN: st_valid=0, ks_valid=0, st_shares=all ones → sbox_in=0. Without the macro → sbox_in=all ones.
- Shares check with d=3: ST word = S-box output of (shares XOR-recombining to 0x00 per byte) → recombined res_shares = 0x63636363 when st_out_valid.
